// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package prog_loader_pkg;

    localparam int BLOCK_SIZE = 128;                 // RAM line width in bits
    localparam int RAM_DEPTH  = 8192;                // lines in main memory
    localparam int NUMS_BYTE  = BLOCK_SIZE / 8;      // byte lanes per line
    localparam int LINE_AW    = $clog2(RAM_DEPTH);
    localparam int LANE_AW    = $clog2(NUMS_BYTE);

    localparam logic [31:0] PROG_KEY  = 32'h5445_4B4E;  // received MSB byte first
    localparam logic [31:0] MAX_BYTES = 32'(RAM_DEPTH * NUMS_BYTE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_LEN,
        ST_DATA,
        ST_FLUSH,
        ST_DONE
    } ld_state_t;

    // A load never runs past the end of memory.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len > MAX_BYTES) ? MAX_BYTES : len;
    endfunction

endpackage

// File: rtl/prog_uart_loader_if.sv
// RAM line write port driven by the program loader.
// Latency: n/a (wiring only); ports: we, line addr, line data, byte strobes.
// Backpressure: none, the RAM accepts every write pulse.
interface prog_uart_loader_if;
    import prog_loader_pkg::*;

    logic                  ram_we_o;
    logic [LINE_AW-1:0]    ram_addr_o;
    logic [BLOCK_SIZE-1:0] ram_wdata_o;
    logic [NUMS_BYTE-1:0]  ram_wstrb_o;

    modport master (
        output ram_we_o,
        output ram_addr_o,
        output ram_wdata_o,
        output ram_wstrb_o
    );

    modport slave (
        input ram_we_o,
        input ram_addr_o,
        input ram_wdata_o,
        input ram_wstrb_o
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: clk_o/rst_n, rx_i (async) in; byte_o, byte_valid_o, frame_err_o out.
// Latency: byte_valid_o pulses at mid stop bit, about 9.5 bit times after the start edge.
// Backpressure: none, the consumer must take byte_o on the valid pulse.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_o,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} rx_state_t;

    rx_state_t     r_st, w_st_nxt;
    logic [1:0]    r_sync;
    logic          r_prev;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_rx;

    assign w_rx   = r_sync[1];
    assign byte_o = r_shift;

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_st    <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync  <= {r_sync[0], rx_i};
            r_prev  <= w_rx;
            r_st    <= w_st_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_st_nxt     = r_st;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        case (r_st)
            U_IDLE: begin
                // Only a high-to-low transition starts a frame, so a line
                // stuck low after a bad stop bit is not re-read as data.
                if (r_prev && !w_rx) begin
                    w_st_nxt  = U_START;
                    w_cnt_nxt = '0;
                end
            end
            U_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    w_st_nxt  = w_rx ? U_IDLE : U_DATA;   // glitch rejection
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            U_DATA: begin
                if (r_cnt == FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};   // LSB first
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_st_nxt = U_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            U_STOP: begin
                if (r_cnt == FULL) begin
                    w_cnt_nxt    = '0;
                    w_st_nxt     = U_IDLE;
                    byte_valid_o = w_rx;
                    frame_err_o  = !w_rx;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_st_nxt = U_IDLE;
        endcase
    end

endmodule

// File: rtl/prog_uart_loader.sv
// UART program loader: key, LE byte count, payload packed into RAM lines via ram (master).
// Ports: clk_o, rst_n, prog_rx_i in; ram write port, system_reset_o, prog_mode_led_o out.
// Latency: line write one cycle after its last byte; no backpressure, writes are fire-and-forget.
module prog_uart_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYC  = 50_000_000
) (
    input  logic               clk_o,
    input  logic               rst_n,
    input  logic               prog_rx_i,
    prog_uart_loader_if.master ram,
    output logic               system_reset_o,
    output logic               prog_mode_led_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [7:0] w_byte;
    logic       w_byte_vld;
    logic       w_frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_o        (clk_o),
        .rst_n        (rst_n),
        .rx_i         (prog_rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_vld),
        .frame_err_o  (w_frame_err)
    );

    ld_state_t             r_state, w_state_nxt;
    logic [23:0]           r_key;      // upper three bytes of the sliding key window
    logic [23:0]           r_len;      // upper three bytes of the LE count window
    logic [1:0]            r_len_idx;
    logic [31:0]           r_left;     // payload bytes still expected
    logic [LANE_AW-1:0]    r_lane;
    logic [LINE_AW-1:0]    r_line;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic [NUMS_BYTE-1:0]  r_wstrb;
    logic                  r_we;
    logic [TO_W-1:0]       r_to_cnt;

    logic [31:0] w_key_nxt;
    logic [31:0] w_len_full;
    logic        w_key_hit;
    logic        w_loading;
    logic        w_timeout;
    logic        w_line_end;

    assign w_key_nxt  = {r_key, w_byte};
    assign w_key_hit  = (w_key_nxt == PROG_KEY);
    assign w_len_full = {w_byte, r_len};
    assign w_loading  = (r_state == ST_LEN) || (r_state == ST_DATA);
    assign w_timeout  = w_loading && !w_byte_vld && (r_to_cnt == TO_LAST);
    assign w_line_end = (&r_lane) || (r_left == 32'd1);

    assign ram.ram_we_o    = r_we;
    assign ram.ram_addr_o  = r_line;
    assign ram.ram_wdata_o = r_wdata;
    assign ram.ram_wstrb_o = r_wstrb;

    // CPU is held in reset for the whole load, released again from DONE on.
    assign system_reset_o  = !(w_loading || (r_state == ST_FLUSH));
    assign prog_mode_led_o = (r_state != ST_IDLE);

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_KEY: begin
                if (w_byte_vld) begin
                    w_state_nxt = w_key_hit ? ST_LEN : ST_KEY;
                end
            end
            ST_LEN: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_vld && (r_len_idx == 2'd3)) begin
                    w_state_nxt = (w_len_full == 32'd0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_vld && (r_left == 32'd1)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_DONE;   // final line write is on the bus here
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_len     <= '0;
            r_len_idx <= '0;
            r_left    <= '0;
            r_lane    <= '0;
            r_line    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_we      <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_we     <= 1'b0;
            r_to_cnt <= (w_loading && !w_byte_vld) ? r_to_cnt + 1'b1 : '0;

            // Retire the line that was on the bus this cycle.
            if (r_we) begin
                r_line  <= r_line + 1'b1;
                r_wdata <= '0;
                r_wstrb <= '0;
            end

            case (r_state)
                ST_IDLE, ST_KEY: begin
                    // Window is emptied on a hit so a stale key cannot re-trigger,
                    // and on a garbled frame so the search restarts cleanly.
                    if (w_byte_vld) begin
                        r_key <= w_key_hit ? '0 : w_key_nxt[23:0];
                    end else if (w_frame_err) begin
                        r_key <= '0;
                    end
                    if (w_byte_vld && w_key_hit) begin
                        r_len_idx <= '0;
                        r_lane    <= '0;
                        r_line    <= '0;
                        r_wdata   <= '0;
                        r_wstrb   <= '0;
                    end
                end
                ST_LEN: begin
                    if (w_byte_vld) begin
                        r_len     <= w_len_full[31:8];
                        r_len_idx <= r_len_idx + 1'b1;
                        r_left    <= clamp_len(w_len_full);
                    end
                end
                ST_DATA: begin
                    if (w_byte_vld) begin
                        r_wdata[{r_lane, 3'b000} +: 8] <= w_byte;
                        r_wstrb[r_lane]                <= 1'b1;
                        r_lane                         <= r_lane + 1'b1;
                        r_left                         <= r_left - 1'b1;
                        if (w_line_end) begin
                            r_we <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Abort drops whatever partial line was being assembled.
            if (w_timeout) begin
                r_wdata <= '0;
                r_wstrb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_uart_loader.sv
module tb_prog_uart_loader;
    import prog_loader_pkg::*;

    localparam int CPB    = 8;
    localparam int TO_CYC = 2000;

    logic clk_o   = 1'b0;
    logic rst_n   = 1'b0;
    logic prog_rx = 1'b1;
    logic system_reset_o;
    logic prog_mode_led_o;

    always #5 clk_o = ~clk_o;

    prog_uart_loader_if ram_if();

    prog_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk_o           (clk_o),
        .rst_n           (rst_n),
        .prog_rx_i       (prog_rx),
        .ram             (ram_if),
        .system_reset_o  (system_reset_o),
        .prog_mode_led_o (prog_mode_led_o)
    );

    typedef struct {
        logic [LINE_AW-1:0]    addr;
        logic [BLOCK_SIZE-1:0] data;
        logic [NUMS_BYTE-1:0]  strb;
    } wr_t;

    wr_t  exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_wr    = 0;
    logic prev_we = 1'b0;

    // Write monitor / scoreboard.
    always @(negedge clk_o) begin
        wr_t e;
        if (ram_if.ram_we_o === 1'b1) begin
            n_wr++;
            checks++;
            if (prev_we === 1'b1) begin
                errors++;
                $display("FAIL we_back_to_back: ram_we_o high on two consecutive cycles");
            end
            checks++;
            if (system_reset_o !== 1'b0) begin
                errors++;
                $display("FAIL wr_cpu_held: system_reset_o=%b during write, required 0", system_reset_o);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d strb=%h, no write expected",
                         ram_if.ram_addr_o, ram_if.ram_wstrb_o);
            end else begin
                e = exp_q.pop_front();
                if (ram_if.ram_addr_o !== e.addr) begin
                    errors++;
                    $display("FAIL wr_addr: got %0d required %0d", ram_if.ram_addr_o, e.addr);
                end
                checks++;
                if (ram_if.ram_wstrb_o !== e.strb) begin
                    errors++;
                    $display("FAIL wr_strb: got %h required %h", ram_if.ram_wstrb_o, e.strb);
                end
                checks++;
                if (ram_if.ram_wdata_o !== e.data) begin
                    errors++;
                    $display("FAIL wr_data: got %h required %h", ram_if.ram_wdata_o, e.data);
                end
            end
        end
        prev_we = ram_if.ram_we_o;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        prog_rx = 1'b0;
        repeat (CPB) @(negedge clk_o);
        for (int i = 0; i < 8; i++) begin
            prog_rx = b[i];
            repeat (CPB) @(negedge clk_o);
        end
        prog_rx = stop_bit;
        repeat (CPB) @(negedge clk_o);
        prog_rx = 1'b1;
        repeat (CPB) @(negedge clk_o);
    endtask

    task automatic send_key();
        logic [31:0] k;
        k = 32'h5445_4B4E;
        for (int i = 3; i >= 0; i--) send_byte(k[8*i +: 8], 1'b1);
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle(input int max_cyc, output int cyc);
        cyc = 0;
        while (prog_mode_led_o !== 1'b0 && cyc < max_cyc) begin
            @(negedge clk_o);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk_o);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_o);
        checks++; if (ram_if.ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", ram_if.ram_we_o); end
        checks++; if (ram_if.ram_addr_o !== '0) begin errors++; $display("FAIL rst_addr: got %0d required 0", ram_if.ram_addr_o); end
        checks++; if (ram_if.ram_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata: got %h required 0", ram_if.ram_wdata_o); end
        checks++; if (ram_if.ram_wstrb_o !== '0) begin errors++; $display("FAIL rst_wstrb: got %h required 0", ram_if.ram_wstrb_o); end
        checks++; if (system_reset_o !== 1'b1) begin errors++; $display("FAIL rst_sysrst: got %b required 1", system_reset_o); end
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL rst_led: got %b required 0", prog_mode_led_o); end
    endtask

    task automatic test_full_load();
        wr_t w;
        int  base, cyc;
        base = n_wr;
        for (int l = 0; l < 2; l++) begin
            w.addr = LINE_AW'(l);
            w.strb = '1;
            w.data = '0;
            for (int k = 0; k < 16; k++) w.data[8*k +: 8] = 8'(16*l + k);
            exp_q.push_back(w);
        end
        send_key();
        checks++; if (system_reset_o !== 1'b0) begin errors++; $display("FAIL full_key_sysrst: got %b required 0", system_reset_o); end
        checks++; if (prog_mode_led_o !== 1'b1) begin errors++; $display("FAIL full_key_led: got %b required 1", prog_mode_led_o); end
        send_len(32'h20);
        for (int b = 0; b < 32; b++) send_byte(8'(b), 1'b1);
        wait_idle(200, cyc);
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL full_done_led: got %b required 0 after %0d cycles", prog_mode_led_o, cyc); end
        checks++; if (system_reset_o !== 1'b1) begin errors++; $display("FAIL full_done_sysrst: got %b required 1", system_reset_o); end
        checks++; if (n_wr - base != 2) begin errors++; $display("FAIL full_wr_count: got %0d required 2", n_wr - base); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_pending: %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_partial();
        wr_t w;
        int  base, cyc;
        logic [7:0] pay [5];
        pay  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        base = n_wr;
        w.addr = '0;
        w.strb = 16'h001F;
        w.data = '0;
        w.data[39:0] = 40'hEE_DDCC_BBAA;
        exp_q.push_back(w);
        send_key();
        send_len(32'd5);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
        wait_idle(200, cyc);
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL part_done_led: got %b required 0", prog_mode_led_o); end
        checks++; if (n_wr - base != 1) begin errors++; $display("FAIL part_wr_count: got %0d required 1", n_wr - base); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL part_pending: %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_junk_key();
        int base, cyc;
        logic [7:0] seq [5];
        seq  = '{8'h11, 8'h54, 8'h45, 8'h4B, 8'h4E};
        base = n_wr;
        for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
        checks++; if (system_reset_o !== 1'b0) begin errors++; $display("FAIL junk_sysrst: got %b required 0", system_reset_o); end
        checks++; if (prog_mode_led_o !== 1'b1) begin errors++; $display("FAIL junk_led: got %b required 1", prog_mode_led_o); end
        send_len(32'd0);     // zero count goes straight to DONE
        wait_idle(50, cyc);
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL zero_len_led: got %b required 0", prog_mode_led_o); end
        checks++; if (system_reset_o !== 1'b1) begin errors++; $display("FAIL zero_len_sysrst: got %b required 1", system_reset_o); end
        checks++; if (n_wr != base) begin errors++; $display("FAIL zero_len_wr: got %0d writes required 0", n_wr - base); end
    endtask

    task automatic test_timeout();
        int base, cyc;
        base = n_wr;
        send_key();
        send_len(32'h10);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b1);
        wait_idle(2600, cyc);
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL to_led: got %b required 0 within 2600 cycles", prog_mode_led_o); end
        checks++; if (cyc < 1900 || cyc > 2100) begin errors++; $display("FAIL to_delay: abort after %0d cycles, required about %0d", cyc, TO_CYC); end
        checks++; if (system_reset_o !== 1'b1) begin errors++; $display("FAIL to_sysrst: got %b required 1", system_reset_o); end
        checks++; if (n_wr != base) begin errors++; $display("FAIL to_wr: got %0d writes required 0", n_wr - base); end
    endtask

    task automatic test_frame_err();
        wr_t w;
        int  base, cyc;
        base = n_wr;
        w.addr = '0;
        w.strb = 16'h0003;
        w.data = '0;
        w.data[15:0] = 16'h7766;
        exp_q.push_back(w);
        send_key();
        send_len(32'd2);
        send_byte(8'h55, 1'b0);     // bad stop bit, must not count
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        wait_idle(200, cyc);
        checks++; if (n_wr - base != 1) begin errors++; $display("FAIL ferr_wr_count: got %0d required 1", n_wr - base); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_pending: %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = n_wr;
        send_key();
        send_len(32'h20);
        for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1);
        checks++; if (ram_if.ram_wstrb_o !== 16'h001F) begin errors++; $display("FAIL mid_strb: got %h required 001f", ram_if.ram_wstrb_o); end
        checks++; if (ram_if.ram_wdata_o[39:0] !== 40'h04_0302_0100) begin errors++; $display("FAIL mid_data: got %h required 0403020100", ram_if.ram_wdata_o[39:0]); end
        rst_n = 1'b0;
        @(negedge clk_o);
        checks++; if (ram_if.ram_we_o !== 1'b0) begin errors++; $display("FAIL mrst_we: got %b required 0", ram_if.ram_we_o); end
        checks++; if (ram_if.ram_addr_o !== '0) begin errors++; $display("FAIL mrst_addr: got %0d required 0", ram_if.ram_addr_o); end
        checks++; if (ram_if.ram_wdata_o !== '0) begin errors++; $display("FAIL mrst_wdata: got %h required 0", ram_if.ram_wdata_o); end
        checks++; if (ram_if.ram_wstrb_o !== '0) begin errors++; $display("FAIL mrst_wstrb: got %h required 0", ram_if.ram_wstrb_o); end
        checks++; if (system_reset_o !== 1'b1) begin errors++; $display("FAIL mrst_sysrst: got %b required 1", system_reset_o); end
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL mrst_led: got %b required 0", prog_mode_led_o); end
        rst_n = 1'b1;
        repeat (300) @(negedge clk_o);
        checks++; if (n_wr != base) begin errors++; $display("FAIL mrst_wr: got %0d writes required 0", n_wr - base); end
        checks++; if (prog_mode_led_o !== 1'b0) begin errors++; $display("FAIL mrst_led_after: got %b required 0", prog_mode_led_o); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_partial();
        test_junk_key();
        test_timeout();
        test_frame_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
